axis_fifo_pkt_reader: RTL and testbench

- Read-side master for the packet FIFO.
- Issues FIFO read requests and absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer.
- Presents packets on an AXI-Stream master port at full throughput, with packet-boundary enable/stop, per-packet word counting and an oversize error flag.
- Sits between the FIFO read port and downstream stream consumers (DMA, MAC TX).

---
 rtl/axis_fifo_pkg.sv | 18 +
 rtl/axis_skid_buf.sv | 43 ++++
 rtl/axis_fifo_pkt_reader.sv | 131 +++++++++++++
 tb/tb_axis_fifo_pkt_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared types and constants for the packet FIFO read-side stream master.
package axis_fifo_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int PKT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    STOPPING = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [PKT_DATA_W-1:0] data;
    logic                  last;
  } skid_entry_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register buffer that catches FIFO read data and feeds the stream port.
module axis_skid_buf
  import axis_fifo_pkg::*;
#(
  parameter int Width = 33
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic [1:0]       count
);

  logic [Width-1:0] mem [SKID_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // The caller never pushes into a full buffer unless it also pops that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axis_fifo_pkt_reader.sv
// Read-side master for the packet FIFO: issues reads, absorbs the one-cycle read
// latency in a skid buffer and streams packets out with boundary-aware stop.
module axis_fifo_pkt_reader
  import axis_fifo_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int MaxPktLen = 1024,
  parameter int CntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic                 fifo_readReq,
  output logic                 fifo_readDataReady,
  input  logic [DataWidth-1:0] fifo_readData,
  input  logic                 fifo_readDataValid,
  input  logic                 fifo_readDataLast,
  input  logic                 fifo_empty,
  output logic [DataWidth-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 busy,
  output logic [CntWidth-1:0]  pkt_count,
  output logic [CntWidth-1:0]  last_pkt_words,
  output logic                 oversize_err
);

  localparam logic [31:0] MaxLen = 32'(MaxPktLen);

  rd_state_e           state;
  rd_state_e           state_next;
  logic                inflight;
  logic                fire;
  logic                beat;
  logic                mid_packet;
  logic                pending_last;
  logic                issue_ok;
  logic                room;
  logic [1:0]          occupancy;
  logic [1:0]          last_cnt;
  logic [2:0]          slots_used;
  logic [CntWidth-1:0] word_cnt;
  logic [CntWidth-1:0] word_inc;
  logic [DataWidth:0]  head;

  axis_skid_buf #(
    .Width(DataWidth + 1)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (inflight),
    .push_data({fifo_readData, fifo_readDataLast}),
    .out_valid(m_tvalid),
    .out_ready(m_tready),
    .out_data (head),
    .count    (occupancy)
  );

  assign m_tdata    = head[DataWidth:1];
  assign m_tlast    = head[0];
  assign beat       = m_tvalid & m_tready;
  assign mid_packet = (word_cnt != '0);
  assign word_inc   = (word_cnt == '1) ? word_cnt : word_cnt + 1'b1;
  assign busy       = (state != IDLE);

  // A last word already arriving or buffered means the current packet is fully fetched.
  assign pending_last = (inflight & fifo_readDataLast) | (last_cnt != 2'd0);
  assign issue_ok     = ((state == ACTIVE) & enable) |
                        ((state != IDLE) & mid_packet & ~pending_last);

  // Slot accounting counts this cycle's pop so back-to-back reads keep full throughput.
  assign slots_used         = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, beat};
  assign room               = (slots_used < 3'(SKID_DEPTH));
  assign fifo_readReq       = (state != IDLE);
  assign fifo_readDataReady = ~fifo_empty & issue_ok & room;
  assign fire               = fifo_readReq & fifo_readDataReady & ~fifo_empty;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!enable) begin
          if (mid_packet) state_next = STOPPING;
          else if (!inflight && occupancy == 2'd0) state_next = IDLE;
        end
      end
      STOPPING: begin
        if (enable) state_next = ACTIVE;
        else if (!mid_packet && !inflight && occupancy == 2'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
      last_cnt <= 2'd0;
    end else begin
      state    <= state_next;
      inflight <= fire;
      last_cnt <= last_cnt + {1'b0, inflight & fifo_readDataLast} - {1'b0, beat & m_tlast};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt       <= '0;
      pkt_count      <= '0;
      last_pkt_words <= '0;
      oversize_err   <= 1'b0;
    end else if (beat) begin
      if (m_tlast) begin
        last_pkt_words <= word_inc;
        word_cnt       <= '0;
        pkt_count      <= pkt_count + 1'b1;
      end else begin
        word_cnt <= word_inc;
        if (32'(word_inc) > MaxLen) oversize_err <= 1'b1;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) inflight |-> fifo_readDataValid);

endmodule

// File: tb/tb_axis_fifo_pkt_reader.sv
// Directed bench for axis_fifo_pkt_reader with a behavioural one-cycle-latency FIFO.
module tb_axis_fifo_pkt_reader;
  import axis_fifo_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          m_tready = 1'b0;
  logic          fifo_readReq;
  logic          fifo_readDataReady;
  logic [DW-1:0] fifo_readData = '0;
  logic          fifo_readDataValid = 1'b0;
  logic          fifo_readDataLast = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          busy;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] last_pkt_words;
  logic          oversize_err;

  always #5 clk = ~clk;

  axis_fifo_pkt_reader #(
    .DataWidth(DW),
    .MaxPktLen(4),
    .CntWidth (CW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .fifo_readReq      (fifo_readReq),
    .fifo_readDataReady(fifo_readDataReady),
    .fifo_readData     (fifo_readData),
    .fifo_readDataValid(fifo_readDataValid),
    .fifo_readDataLast (fifo_readDataLast),
    .fifo_empty        (fifo_empty),
    .m_tdata           (m_tdata),
    .m_tvalid          (m_tvalid),
    .m_tready          (m_tready),
    .m_tlast           (m_tlast),
    .busy              (busy),
    .pkt_count         (pkt_count),
    .last_pkt_words    (last_pkt_words),
    .oversize_err      (oversize_err)
  );

  // FIFO model: data appears one cycle after an accepted read.
  skid_entry_t fmem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        flush = 1'b0;
  logic        fifo_fire;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_fire  = fifo_readReq & fifo_readDataReady & ~fifo_empty;

  always @(posedge clk) begin
    fifo_readDataValid <= fifo_fire;
    if (fifo_fire) begin
      fifo_readData     <= fmem[rd_ptr].data;
      fifo_readDataLast <= fmem[rd_ptr].last;
      rd_ptr            <= rd_ptr + 1;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end
  end

  typedef struct {
    logic        en;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        exp_rd_ready;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t        rows[$];
  int          errors = 0;
  int          checks = 0;
  int          t1_first, t1_last, t3_first, t3_last, t4_first, t4_last;
  int          nb, beats, pushed, popped;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  int          bcyc [4];
  logic [31:0] bdata [4];
  logic        blast [4];
  int          exp_cyc_gap [4] = '{3, 4, 14, 15};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_row(input logic en, rdy, v, input logic [31:0] d,
                         input logic l, rr, b, e);
    vec_t r;
    r.en = en; r.rdy = rdy; r.exp_valid = v; r.exp_data = d; r.exp_last = l;
    r.exp_rd_ready = rr; r.exp_busy = b; r.exp_err = e;
    rows.push_back(r);
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    fmem[wr_ptr] = {d, l};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    enable = 1'b0; m_tready = 1'b0; flush = 1'b1; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b0; reset_n = 1'b1;
  endtask

  // One table row: drive at the falling edge, then compare once the logic settles.
  task automatic apply_stimulus(input vec_t r, input string tag);
    @(negedge clk);
    enable = r.en; m_tready = r.rdy;
    #1;
    check_output({tag, " tvalid"}, 32'(m_tvalid), 32'(r.exp_valid));
    if (r.exp_valid) begin
      check_output({tag, " tdata"}, m_tdata, r.exp_data);
      check_output({tag, " tlast"}, 32'(m_tlast), 32'(r.exp_last));
    end
    check_output({tag, " rd_ready"}, 32'(fifo_readDataReady), 32'(r.exp_rd_ready));
    check_output({tag, " busy"}, 32'(busy), 32'(r.exp_busy));
    check_output({tag, " err"}, 32'(oversize_err), 32'(r.exp_err));
  endtask

  task automatic run_rows(input int first, input int last_row, input string tag);
    for (int i = first; i <= last_row; i++)
      apply_stimulus(rows[i], $sformatf("%s c%0d", tag, i - first));
  endtask

  initial begin
    // en rdy valid data last rd_ready busy err
    t1_first = rows.size();
    add_row(1, 1, 0, 32'h00, 0, 0, 0, 0);
    add_row(1, 1, 0, 32'h00, 0, 1, 1, 0);
    add_row(1, 1, 0, 32'h00, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h10, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h11, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h12, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h13, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h14, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h15, 0, 1, 1, 1);
    add_row(1, 1, 1, 32'h16, 0, 0, 1, 1);
    add_row(1, 1, 1, 32'h17, 1, 0, 1, 1);
    add_row(1, 1, 0, 32'h00, 0, 0, 1, 1);
    t1_last = rows.size() - 1;

    t3_first = rows.size();
    add_row(1, 1, 0, 32'h00, 0, 0, 0, 0);
    add_row(1, 1, 0, 32'h00, 0, 1, 1, 0);
    add_row(1, 1, 0, 32'h00, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h20, 0, 1, 1, 0);
    add_row(0, 1, 1, 32'h21, 0, 0, 1, 0);
    add_row(0, 1, 1, 32'h22, 1, 0, 1, 0);
    add_row(0, 1, 0, 32'h00, 0, 0, 1, 0);
    add_row(0, 1, 0, 32'h00, 0, 0, 0, 0);
    add_row(0, 1, 0, 32'h00, 0, 0, 0, 0);
    t3_last = rows.size() - 1;

    t4_first = rows.size();
    add_row(1, 1, 0, 32'h00, 0, 0, 0, 0);
    add_row(1, 1, 0, 32'h00, 0, 1, 1, 0);
    add_row(1, 1, 0, 32'h00, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h40, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h41, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h42, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h43, 0, 1, 1, 0);
    add_row(1, 1, 1, 32'h44, 0, 0, 1, 0);
    add_row(1, 1, 1, 32'h45, 1, 0, 1, 1);
    add_row(1, 1, 0, 32'h00, 0, 0, 1, 1);
    t4_last = rows.size() - 1;

    // Reset state, then an 8-word packet at full rate.
    do_reset();
    #1;
    check_output("rst tvalid", 32'(m_tvalid), 0);
    check_output("rst tdata", m_tdata, 0);
    check_output("rst tlast", 32'(m_tlast), 0);
    check_output("rst busy", 32'(busy), 0);
    check_output("rst pkt_count", 32'(pkt_count), 0);
    check_output("rst last_words", 32'(last_pkt_words), 0);
    check_output("rst err", 32'(oversize_err), 0);
    for (int i = 0; i < 8; i++) push_word(32'h10 + i, i == 7);
    #1;
    check_output("idle readReq", 32'(fifo_readReq), 0);
    check_output("idle rd_ready", 32'(fifo_readDataReady), 0);
    run_rows(t1_first, t1_last, "t1");
    check_output("t1 pkt_count", 32'(pkt_count), 1);
    check_output("t1 last_words", 32'(last_pkt_words), 8);

    // Same stream with a stalling consumer.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h10 + i, i == 7);
    beats = 0; pushed = 0; popped = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 60 && beats < 8; cyc++) begin
      @(negedge clk);
      enable = 1'b1; m_tready = (cyc % 2 == 0);
      #1;
      if (prev_stall) begin
        check_output("t2 stall tvalid", 32'(m_tvalid), 1);
        check_output("t2 stall tdata", m_tdata, prev_data);
        check_output("t2 stall tlast", 32'(m_tlast), 32'(prev_last));
      end
      if ((pushed - popped + int'(fifo_readDataValid)) == 2 && !(m_tvalid && m_tready))
        check_output("t2 full rd_ready", 32'(fifo_readDataReady), 0);
      if (m_tvalid && m_tready) begin
        check_output("t2 beat data", m_tdata, 32'h10 + beats);
        check_output("t2 beat last", 32'(m_tlast), 32'(beats == 7));
        beats++;
      end
      prev_stall = m_tvalid & ~m_tready; prev_data = m_tdata; prev_last = m_tlast;
      pushed += int'(fifo_readDataValid);
      popped += int'(m_tvalid & m_tready);
    end
    check_output("t2 beat count", beats, 8);
    @(negedge clk); #1;
    check_output("t2 no extra", 32'(m_tvalid), 0);
    check_output("t2 pkt_count", 32'(pkt_count), 1);
    check_output("t2 last_words", 32'(last_pkt_words), 8);

    // Enable drops mid-packet: packet 1 finishes, packet 2 stays in the FIFO.
    do_reset();
    for (int i = 0; i < 3; i++) push_word(32'h20 + i, i == 2);
    for (int i = 0; i < 5; i++) push_word(32'h30 + i, i == 4);
    run_rows(t3_first, t3_last, "t3");
    check_output("t3 pkt_count", 32'(pkt_count), 1);
    check_output("t3 last_words", 32'(last_pkt_words), 3);
    check_output("t3 fifo left", wr_ptr - rd_ptr, 5);

    // Oversize packet of 6 words with a limit of 4.
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'h40 + i, i == 5);
    run_rows(t4_first, t4_last, "t4");
    check_output("t4 last_words", 32'(last_pkt_words), 6);
    check_output("t4 pkt_count", 32'(pkt_count), 1);

    // FIFO runs dry after two words and is refilled later.
    do_reset();
    push_word(32'h50, 0); push_word(32'h51, 0);
    nb = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 12) begin
        push_word(32'h52, 0); push_word(32'h53, 1);
      end
      enable = 1'b1; m_tready = 1'b1;
      #1;
      if (m_tvalid) begin
        if (nb < 4) begin bcyc[nb] = cyc; bdata[nb] = m_tdata; blast[nb] = m_tlast; end
        nb++;
      end
    end
    check_output("t5 beat count", nb, 4);
    for (int i = 0; i < 4 && i < nb; i++) begin
      check_output($sformatf("t5 beat%0d cycle", i), bcyc[i], exp_cyc_gap[i]);
      check_output($sformatf("t5 beat%0d data", i), bdata[i], 32'h50 + i);
      check_output($sformatf("t5 beat%0d last", i), 32'(blast[i]), 32'(i == 3));
    end
    check_output("t5 last_words", 32'(last_pkt_words), 4);
    check_output("t5 err at limit", 32'(oversize_err), 0);

    // Asynchronous reset while the third beat is presented.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h60 + i, i == 7);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      enable = 1'b1; m_tready = 1'b1;
      #1;
      if (cyc >= 3) check_output($sformatf("t6 pre c%0d data", cyc), m_tdata, 32'h60 + cyc - 3);
    end
    reset_n = 1'b0;
    #1;
    check_output("t6 async tvalid", 32'(m_tvalid), 0);
    check_output("t6 async busy", 32'(busy), 0);
    check_output("t6 async pkt_count", 32'(pkt_count), 0);
    check_output("t6 async readReq", 32'(fifo_readReq), 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    nb = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (m_tvalid) begin
        if (nb < 4) begin bcyc[nb] = cyc; bdata[nb] = m_tdata; blast[nb] = m_tlast; end
        nb++;
      end
    end
    check_output("t6 beat count", nb, 4);
    for (int i = 0; i < 4 && i < nb; i++) begin
      check_output($sformatf("t6 beat%0d cycle", i), bcyc[i], 3 + i);
      check_output($sformatf("t6 beat%0d data", i), bdata[i], 32'h64 + i);
      check_output($sformatf("t6 beat%0d last", i), 32'(blast[i]), 32'(i == 3));
    end
    check_output("t6 pkt_count", 32'(pkt_count), 1);
    check_output("t6 last_words", 32'(last_pkt_words), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
